// File: rtl/text_buffer_scroll.sv
// Character buffer for the VGA text console: dual-port cell RAM with a hardware
// scroll offset, a row/screen clear engine and a one-cycle display read port.
module text_buffer_scroll #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned CHAR_W = 8,
  parameter logic [CHAR_W-1:0] BLANK = '0,
  localparam int unsigned COL_W  = $clog2(COLS),
  localparam int unsigned ROW_W  = $clog2(ROWS),
  localparam int unsigned ADDR_W = $clog2(COLS * ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [CHAR_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              scroll,
  input  logic              clear_all,
  output logic              busy,
  input  logic [COL_W-1:0]  rd_col,
  input  logic [ROW_W-1:0]  rd_row,
  output logic [CHAR_W-1:0] char
);

  localparam int unsigned AW1   = ADDR_W + 1;
  localparam int unsigned CELLS = COLS * ROWS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } state_t;

  state_t            state;
  logic [ROW_W-1:0]  top_row;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_end;

  logic [CHAR_W-1:0] mem [CELLS];

  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_accept;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] row_base;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [CHAR_W-1:0] mem_wdata;

  // Logical (row, col) to RAM address through the scroll offset; one extra bit
  // keeps row + top from wrapping before the compare against ROWS.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col,
                                                 input logic [ROW_W-1:0] top);
    logic [AW1-1:0] phys;
    phys = AW1'(row) + AW1'(top);
    if (phys >= AW1'(ROWS)) phys = phys - AW1'(ROWS);
    return ADDR_W'(phys * AW1'(COLS) + AW1'(col));
  endfunction

  assign wr_in_range = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
  assign rd_in_range = (32'(rd_col) < COLS) && (32'(rd_row) < ROWS);
  assign wr_accept   = (state == IDLE) && wr_en && !scroll && !clear_all && wr_in_range;
  assign wr_addr     = map_addr(wr_row, wr_col, top_row);
  assign rd_addr     = map_addr(rd_row, rd_col, top_row);
  assign row_base    = map_addr('0, '0, top_row);

  // RAM write port is shared: the clear engine owns it whenever it is running.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = BLANK;
    if (state != IDLE) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr;
    end else if (wr_accept) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Command and clear-engine control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      top_row <= '0;
      clr_ptr <= '0;
      clr_end <= '0;
      busy    <= 1'b0;
      wr_ack  <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clear_all) begin
            top_row <= '0;
            clr_ptr <= '0;
            clr_end <= ADDR_W'(CELLS - 1);
            state   <= CLR_ALL;
            busy    <= 1'b1;
          end else if (scroll) begin
            clr_ptr <= row_base;
            clr_end <= row_base + ADDR_W'(COLS - 1);
            top_row <= (top_row == ROW_W'(ROWS - 1)) ? '0 : top_row + ROW_W'(1);
            state   <= CLR_ROW;
            busy    <= 1'b1;
          end else begin
            wr_ack <= wr_accept;
          end
        end
        CLR_ROW, CLR_ALL: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == clr_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Display read port: read-before-write against the same-edge RAM update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char <= '0;
    end else if (rd_in_range) begin
      char <= mem[rd_addr];
    end else begin
      char <= BLANK;
    end
  end

endmodule

// File: tb/tb_text_buffer_scroll.sv
// Self-checking bench for text_buffer_scroll against a logical-screen model
// where scrolling shifts whole rows rather than moving an offset.
module tb_text_buffer_scroll;

  localparam int unsigned COLS   = 4;
  localparam int unsigned ROWS   = 3;
  localparam int unsigned CHAR_W = 8;
  localparam logic [7:0]  BLANK  = 8'h20;
  localparam int unsigned COL_W  = $clog2(COLS);
  localparam int unsigned ROW_W  = $clog2(ROWS);

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [COL_W-1:0] wr_col;
  logic [ROW_W-1:0] wr_row;
  logic [7:0]       wr_data;
  logic             wr_ack;
  logic             scroll;
  logic             clear_all;
  logic             busy;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;
  logic [7:0]       rd_char;

  text_buffer_scroll #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .BLANK(BLANK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data), .wr_ack(wr_ack),
    .scroll(scroll), .clear_all(clear_all), .busy(busy),
    .rd_col(rd_col), .rd_row(rd_row), .char(rd_char)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int c; int r; logic [7:0] d; logic ack; } wr_vec_t;
  typedef struct { int c; int r; logic [7:0] exp; } rd_vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Logical screen as the user sees it: scr[row][col].
  logic [7:0] scr [ROWS][COLS];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [7:0] model_rd(input int c, input int r);
    if (c >= int'(COLS) || r >= int'(ROWS)) return BLANK;
    return scr[r][c];
  endfunction

  function automatic void model_scroll();
    for (int r = 0; r < int'(ROWS) - 1; r++)
      for (int c = 0; c < int'(COLS); c++) scr[r][c] = scr[r+1][c];
    for (int c = 0; c < int'(COLS); c++) scr[ROWS-1][c] = BLANK;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLS); c++) scr[r][c] = BLANK;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a command edge; counts cycles with busy high (bounded).
  task automatic measure_busy(input int exp, input string name);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    check(name, cnt, exp);
  endtask

  task automatic do_scroll(input string name);
    scroll = 1'b1;
    tick();
    scroll = 1'b0;
    model_scroll();
    measure_busy(COLS, name);
  endtask

  task automatic do_clear(input string name);
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    model_clear();
    measure_busy(COLS * ROWS, name);
  endtask

  task automatic do_write(input int c, input int r, input logic [7:0] d, input string name);
    logic exp_ack;
    exp_ack = (c < int'(COLS)) && (r < int'(ROWS));
    wr_en = 1'b1; wr_col = COL_W'(c); wr_row = ROW_W'(r); wr_data = d;
    tick();
    wr_en = 1'b0;
    check(name, wr_ack, exp_ack);
    if (exp_ack) scr[r][c] = d;
  endtask

  task automatic read_chk(input int c, input int r, input string name);
    rd_col = COL_W'(c); rd_row = ROW_W'(r);
    tick();
    check(name, rd_char, model_rd(c, r));
  endtask

  task automatic read_all(input string name);
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLS); c++) read_chk(c, r, name);
  endtask

  wr_vec_t wv[6];
  rd_vec_t rv[7];

  initial begin
    int cnt;
    rst_n = 1'b0; wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_data = '0;
    scroll = 1'b0; clear_all = 1'b0; rd_col = '0; rd_row = '0;

    wv[0] = '{2, 1, 8'h41, 1'b1};
    wv[1] = '{0, 3, 8'h5A, 1'b0};
    wv[2] = '{3, 2, 8'h42, 1'b1};
    wv[3] = '{0, 0, 8'h43, 1'b1};
    wv[4] = '{3, 3, 8'h44, 1'b0};
    wv[5] = '{1, 2, 8'h45, 1'b1};
    rv[0] = '{2, 1, 8'h41};
    rv[1] = '{3, 2, 8'h42};
    rv[2] = '{0, 0, 8'h43};
    rv[3] = '{1, 2, 8'h45};
    rv[4] = '{0, 1, 8'h20};
    rv[5] = '{3, 0, 8'h20};
    rv[6] = '{1, 3, 8'h20};

    // Reset values
    repeat (2) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_ack", wr_ack, 1'b0);
    check("rst_char", rd_char, 8'h00);
    rst_n = 1'b1;
    tick();

    // Full clear
    do_clear("clear_busy_len");
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLS); c++) begin
        rd_col = COL_W'(c); rd_row = ROW_W'(r);
        tick();
        check("clear_blank", rd_char, 8'h20);
      end

    // Back-to-back table writes, in-range and out-of-range
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_col = COL_W'(wv[i].c); wr_row = ROW_W'(wv[i].r); wr_data = wv[i].d;
      tick();
      check("tbl_ack", wr_ack, wv[i].ack);
      if (wv[i].ack) scr[wv[i].r][wv[i].c] = wv[i].d;
    end
    wr_en = 1'b0;
    tick();
    check("ack_single", wr_ack, 1'b0);
    for (int i = 0; i < 7; i++) begin
      rd_col = COL_W'(rv[i].c); rd_row = ROW_W'(rv[i].r);
      tick();
      check("tbl_read", rd_char, rv[i].exp);
    end

    // Fill rows with 0x30+r, scroll once
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLS); c++) do_write(c, r, 8'(8'h30 + r), "fill_ack");
    do_scroll("scroll_busy_len");
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLS); c++) begin
        rd_col = COL_W'(c); rd_row = ROW_W'(r);
        tick();
        check("scroll_rows", rd_char, (r < int'(ROWS) - 1) ? 8'(8'h31 + r) : 8'h20);
      end

    // Three further scrolls wrap the offset
    for (int i = 0; i < 3; i++) do_scroll("scroll_wrap_len");
    read_all("wrap_read");
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLS); c++) do_write(c, r, 8'(8'h50 + r * 4 + c), "pat_ack");
    read_all("pat_read");
    do_scroll("scroll_pat_len");
    read_all("pat_scrolled");

    // Write coincident with scroll is dropped
    wr_en = 1'b1; wr_col = 2'd1; wr_row = 2'd1; wr_data = 8'hEE; scroll = 1'b1;
    tick();
    wr_en = 1'b0; scroll = 1'b0;
    model_scroll();
    check("coincident_ack", wr_ack, 1'b0);
    measure_busy(COLS, "coincident_busy");
    read_all("coincident_read");

    // Write and scroll while busy are ignored
    scroll = 1'b1;
    tick();
    scroll = 1'b0;
    model_scroll();
    cnt = (busy === 1'b1) ? 1 : 0;
    wr_en = 1'b1; wr_col = 2'd2; wr_row = 2'd0; wr_data = 8'h77; scroll = 1'b1;
    tick();
    wr_en = 1'b0; scroll = 1'b0;
    check("busy_wr_ack", wr_ack, 1'b0);
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    check("busy_ignore_len", cnt, COLS);
    read_all("busy_ignore_read");

    // Randomized traffic with same-cycle read and write
    for (int i = 0; i < 300; i++) begin
      int op;
      int wc, wrr, rc, rr;
      logic [7:0] d, exp_char;
      logic exp_ack;
      op  = int'($urandom_range(0, 15));
      wc  = int'($urandom_range(0, 3));
      wrr = int'($urandom_range(0, 3));
      d   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin rc = wc; rr = wrr; end
      else begin rc = int'($urandom_range(0, 3)); rr = int'($urandom_range(0, 3)); end
      rd_col = COL_W'(rc); rd_row = ROW_W'(rr);
      wr_col = COL_W'(wc); wr_row = ROW_W'(wrr); wr_data = d;
      wr_en = ($urandom_range(0, 3) != 0);
      exp_char = model_rd(rc, rr);
      if (op == 0 || op == 1) begin
        if (op == 0) scroll = 1'b1; else clear_all = 1'b1;
        tick();
        scroll = 1'b0; clear_all = 1'b0; wr_en = 1'b0;
        check("rnd_cmd_read", rd_char, exp_char);
        check("rnd_cmd_ack", wr_ack, 1'b0);
        if (op == 0) begin
          model_scroll();
          measure_busy(COLS, "rnd_scroll_len");
        end else begin
          model_clear();
          measure_busy(COLS * ROWS, "rnd_clear_len");
        end
      end else begin
        exp_ack = wr_en && (wrr < int'(ROWS));
        tick();
        wr_en = 1'b0;
        check("rnd_read", rd_char, exp_char);
        check("rnd_ack", wr_ack, exp_ack);
        if (exp_ack) scr[wrr][wc] = d;
      end
    end
    read_all("rnd_final");

    // Reset in the middle of a full clear
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    repeat (3) tick();
    check("midclr_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_char", rd_char, 8'h00);
    check("midrst_ack", wr_ack, 1'b0);
    tick();
    rst_n = 1'b1;
    do_write(1, 2, 8'h99, "postrst_ack");
    read_chk(1, 2, "postrst_read");
    do_write(0, 0, 8'h11, "postrst_ack2");
    read_chk(0, 0, "postrst_read2");
    do_clear("postrst_clear_len");
    read_all("postrst_clear_read");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
